// File: rtl/dmem_bus_adapter_pkg.sv
// Shared definitions for the data-memory bus adapter: RV32I load/store
// width encodings (funct3), FSM states, error cause codes and the base
// byte-enable patterns that get shifted into position by the address.
package dmem_bus_pkg;

  localparam int DATA_W = 32;

  // funct3 width encodings seen on core_width_sel_i
  localparam logic [2:0] WIDTH_B  = 3'b000;
  localparam logic [2:0] WIDTH_H  = 3'b001;
  localparam logic [2:0] WIDTH_W  = 3'b010;
  localparam logic [2:0] WIDTH_BU = 3'b100;
  localparam logic [2:0] WIDTH_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_BUS      = 2'b10,
    ERR_TIMEOUT  = 2'b11
  } err_cause_e;

  // Byte-enable patterns for lane 0; B and H are shifted left by addr[1:0]
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/dmem_bus_adapter_if.sv
// Data-memory bus: a valid/ready request channel plus a response channel
// that carries read data or a write acknowledge.
//   master: the adapter (drives req_*, receives req_ready and rsp_*)
//   slave : the interconnect / memory side
interface dmem_bus_if #(
  parameter int ADDR_W = 32
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;   // word aligned, bits [1:0] always zero
  logic [3:0]        req_be;
  logic [31:0]       req_wdata;  // already lane-steered
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;  // raw word, not yet lane-extracted
  logic              rsp_err;    // qualified by rsp_valid

  modport master (
    output req_valid, req_we, req_addr, req_be, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_be, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_bus_adapter_lane_align.sv
// lsu_lane_align: purely combinational RV32I lane logic.
//   Request side : width_sel/addr_lo/wdata -> be, wdata_lane, align_err
//                  (align_err also flags undefined width encodings)
//   Load side    : ld_width_sel/ld_addr_lo/ld_word -> ld_data, the selected
//                  byte/half/word sign- or zero-extended to 32 bits
module lsu_lane_align
  import dmem_bus_pkg::*;
(
  input  logic [2:0]        width_sel,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] wdata,
  output logic [3:0]        be,
  output logic [DATA_W-1:0] wdata_lane,
  output logic              align_err,
  input  logic [2:0]        ld_width_sel,
  input  logic [1:0]        ld_addr_lo,
  input  logic [DATA_W-1:0] ld_word,
  output logic [DATA_W-1:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    be         = '0;
    wdata_lane = '0;
    align_err  = 1'b0;
    case (width_sel)
      WIDTH_B, WIDTH_BU: begin
        be         = BE_BYTE << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
      end
      WIDTH_H, WIDTH_HU: begin
        be         = BE_HALF << addr_lo;
        wdata_lane = {2{wdata[15:0]}};
        align_err  = addr_lo[0];
      end
      WIDTH_W: begin
        be         = BE_WORD;
        wdata_lane = wdata;
        align_err  = |addr_lo;
      end
      default: align_err = 1'b1;
    endcase
  end

  always_comb begin
    ld_byte = 8'(ld_word >> {ld_addr_lo, 3'b000});
    ld_half = ld_addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
    case (ld_width_sel)
      WIDTH_B:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      WIDTH_BU: ld_data = {24'h0, ld_byte};
      WIDTH_H:  ld_data = {{16{ld_half[15]}}, ld_half};
      WIDTH_HU: ld_data = {16'h0, ld_half};
      default:  ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/dmem_bus_adapter.sv
// dmem_bus_adapter: turns the core's single-cycle data-memory port into a
// valid/ready request + response transaction, stalling the pipeline while
// the transaction is outstanding.
//   clk_i, rst_i          : clock, synchronous active-low reset
//   core_re_i/core_we_i   : load/store request (store wins), held while stalled
//   core_width_sel_i      : funct3 width, core_addr_i byte address
//   core_wdata_i          : right-aligned store data
//   core_rdata_o          : formatted load data, valid in the DONE cycle
//   core_stall_o          : pipeline hold
//   core_err_o/_cause_o   : one-cycle error pulse and cause
//   bus                   : dmem_bus_if master (request + response channels)
module dmem_bus_adapter
  import dmem_bus_pkg::*;
#(
  parameter int ADDR_W  = 32,   // must be <= 32
  parameter int TIMEOUT = 255   // cycles allowed in REQ+RSP, >= 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              core_re_i,
  input  logic              core_we_i,
  input  logic [2:0]        core_width_sel_i,
  input  logic [31:0]       core_addr_i,
  input  logic [DATA_W-1:0] core_wdata_i,
  output logic [DATA_W-1:0] core_rdata_o,
  output logic              core_stall_o,
  output logic              core_err_o,
  output logic [1:0]        core_err_cause_o,
  dmem_bus_if.master        bus
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  state_e            state_q;
  logic              req_valid_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  err_cause_e        cause_q;

  logic              we_q;
  logic [2:0]        width_q;
  logic [1:0]        addr_lo_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        be_q;
  logic [DATA_W-1:0] wdata_q;

  logic [3:0]        be_next;
  logic [DATA_W-1:0] wdata_next;
  logic [DATA_W-1:0] ld_data;
  logic              align_err;
  logic              access;
  logic              start;
  logic              misalign_err;
  logic              timeout_hit;

  lsu_lane_align u_lane (
    .width_sel    (core_width_sel_i),
    .addr_lo      (core_addr_i[1:0]),
    .wdata        (core_wdata_i),
    .be           (be_next),
    .wdata_lane   (wdata_next),
    .align_err    (align_err),
    .ld_width_sel (width_q),
    .ld_addr_lo   (addr_lo_q),
    .ld_word      (bus.rsp_rdata),
    .ld_data      (ld_data)
  );

  assign access       = core_re_i | core_we_i;
  assign start        = (state_q == ST_IDLE) & access & ~align_err;
  assign misalign_err = (state_q == ST_IDLE) & access & align_err;
  // Last permitted REQ/RSP cycle: cnt_q counts cycles already spent there
  assign timeout_hit  = (cnt_q == CNT_W'(TIMEOUT - 1));

  // Control FSM; rdata/err are registered so they appear only in DONE
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      req_valid_q <= 1'b0;
      cnt_q       <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      cause_q     <= ERR_NONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q     <= ST_REQ;
            req_valid_q <= 1'b1;
            cnt_q       <= '0;
          end
        end
        ST_REQ: begin
          // Timeout wins over a same-cycle accept so REQ+RSP never exceeds TIMEOUT
          if (timeout_hit) begin
            state_q     <= ST_DONE;
            req_valid_q <= 1'b0;
            err_q       <= 1'b1;
            cause_q     <= ERR_TIMEOUT;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (bus.req_ready) begin
              state_q     <= ST_RSP;
              req_valid_q <= 1'b0;
            end
          end
        end
        ST_RSP: begin
          // A response arriving in the last permitted cycle still counts
          if (bus.rsp_valid) begin
            state_q <= ST_DONE;
            if (bus.rsp_err) begin
              err_q   <= 1'b1;
              cause_q <= ERR_BUS;
            end else begin
              rdata_q <= we_q ? '0 : ld_data;
            end
          end else if (timeout_hit) begin
            state_q <= ST_DONE;
            err_q   <= 1'b1;
            cause_q <= ERR_TIMEOUT;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          rdata_q <= '0;
          err_q   <= 1'b0;
          cause_q <= ERR_NONE;
        end
      endcase
    end
  end

  // Request latch: data only, captured when a legal access is accepted
  always_ff @(posedge clk_i) begin
    if (start) begin
      we_q      <= core_we_i;
      width_q   <= core_width_sel_i;
      addr_lo_q <= core_addr_i[1:0];
      addr_q    <= {core_addr_i[ADDR_W-1:2], 2'b00};
      be_q      <= be_next;
      wdata_q   <= wdata_next;
    end
  end

  // Request fields are forced to zero when idle so the unreset latch never leaks
  assign bus.req_valid = req_valid_q;
  assign bus.req_we    = req_valid_q & we_q;
  assign bus.req_addr  = req_valid_q ? addr_q  : '0;
  assign bus.req_be    = req_valid_q ? be_q    : '0;
  assign bus.req_wdata = req_valid_q ? wdata_q : '0;

  assign core_rdata_o     = rdata_q;
  assign core_stall_o     = start | (state_q == ST_REQ) | (state_q == ST_RSP);
  assign core_err_o       = err_q | misalign_err;
  assign core_err_cause_o = misalign_err ? ERR_MISALIGN : cause_q;

endmodule
